// File: rtl/dump_pkg.sv
// Shared types and sizing helpers for the CPU state-dump engine.
package dump_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FREEZE,
    PC,
    REG,
    MEM,
    DRAIN
  } dump_state_e;

  localparam int unsigned RF_ADDR_W = 5;
  localparam int unsigned DM_ADDR_W = 32;

  // Words in one complete dump: PC, every register, every memory word.
  function automatic int unsigned dump_words(input int unsigned nr, input int unsigned nm);
    return 1 + nr + nm;
  endfunction

  // Index counter width; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned nr, input int unsigned nm);
    int unsigned m;
    m = (nr > nm) ? nr : nm;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/dump_out_stage.sv
// Single-entry valid/ready output register carrying a data word and a last marker.
module dump_out_stage #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              last_i,
  output logic              can_load_o,
  output logic              fire_o,
  output logic [DATA_W-1:0] dout_o,
  output logic              dout_valid_o,
  output logic              dout_last_o,
  input  logic              dout_ready_i
);

  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;

  assign can_load_o = !valid_q || dout_ready_i;
  assign fire_o     = valid_q && dout_ready_i;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (load_i && can_load_o) begin
      data_d  = data_i;
      valid_d = 1'b1;
      last_d  = last_i;
    end else if (fire_o) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign dout_o       = data_q;
  assign dout_valid_o = valid_q;
  assign dout_last_o  = last_q;

endmodule

// File: rtl/state_dump_unit.sv
// Freezes the CPU and streams PC, register file and data memory as 32-bit words.
module state_dump_unit
  import dump_pkg::*;
#(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned NUM_MEM  = 32,
  parameter int unsigned DATA_W   = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 dump_req_i,
  input  logic [DATA_W-1:0]    pc_i,
  output logic [RF_ADDR_W-1:0] rf_addr_o,
  input  logic [DATA_W-1:0]    rf_data_i,
  output logic [DM_ADDR_W-1:0] dm_addr_o,
  input  logic [DATA_W-1:0]    dm_data_i,
  output logic                 cpu_hold_o,
  output logic [DATA_W-1:0]    dout_o,
  output logic                 dout_valid_o,
  input  logic                 dout_ready_i,
  output logic                 dout_last_o,
  output logic                 busy_o
);

  localparam int unsigned   IW       = idx_width(NUM_REGS, NUM_MEM);
  localparam logic [IW-1:0] REG_LAST = IW'(NUM_REGS - 1);
  localparam logic [IW-1:0] MEM_LAST = IW'(NUM_MEM - 1);

  dump_state_e       state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              hold_q, hold_d;
  logic              ld;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              can_load;
  logic              fire;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ld      = 1'b0;
    ld_data = '0;
    ld_last = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dump_req_i) state_d = FREEZE;
      end
      FREEZE: begin
        state_d = PC;
      end
      PC: begin
        if (can_load) begin
          ld      = 1'b1;
          ld_data = pc_i;
          idx_d   = '0;
          state_d = REG;
        end
      end
      REG: begin
        if (can_load) begin
          ld      = 1'b1;
          ld_data = rf_data_i;
          if (idx_q == REG_LAST) begin
            idx_d   = '0;
            state_d = MEM;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      MEM: begin
        if (can_load) begin
          ld      = 1'b1;
          ld_data = dm_data_i;
          if (idx_q == MEM_LAST) begin
            ld_last = 1'b1;
            idx_d   = '0;
            state_d = DRAIN;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (fire) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
    // Hold tracks the next state so it is a clean flop output aligned with the FSM.
    hold_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
    end
  end

  assign rf_addr_o  = (state_q == REG) ? RF_ADDR_W'(idx_q) : '0;
  assign dm_addr_o  = (state_q == MEM) ? (DM_ADDR_W'(idx_q) << 2) : '0;
  assign cpu_hold_o = hold_q;
  assign busy_o     = hold_q;

  dump_out_stage #(
    .DATA_W(DATA_W)
  ) u_out (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_i      (ld),
    .data_i      (ld_data),
    .last_i      (ld_last),
    .can_load_o  (can_load),
    .fire_o      (fire),
    .dout_o      (dout_o),
    .dout_valid_o(dout_valid_o),
    .dout_last_o (dout_last_o),
    .dout_ready_i(dout_ready_i)
  );

endmodule
